// File: rtl/pcie_pcs_pkg.sv
// Shared 128b/130b PCS types: sync FSM states, sync-header codes, counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pcie_pcs_pkg;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        SLIP   = 3'd1,
        BLANK  = 3'd2,
        TEST   = 3'd3,
        LOCKED = 3'd4
    } blk_sync_state_e;

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_OS   = 2'b01;

    // Only the two legal sync headers are accepted; 00 and 11 are errors.
    function automatic logic hdr_is_ok(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_OS);
    endfunction

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pcie_blk_err_window.sv
// Counts bad sync headers inside a sliding-free fixed window of locked blocks.
// Latency: unlock is combinational from the current block; counters update next edge.
// Backpressure: none; a block counts only when blk_valid is high.
module pcie_blk_err_window
    import pcie_pcs_pkg::*;
#(
    parameter int WIN_LEN    = 64,
    parameter int ERR_THRESH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic blk_valid,
    input  logic blk_bad,
    output logic unlock
);

    localparam int WW = cnt_width(WIN_LEN - 1);
    localparam int EW = cnt_width(ERR_THRESH);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] ERR_LAST = EW'(ERR_THRESH - 1);

    logic [WW-1:0] win_cnt;
    logic [EW-1:0] err_cnt;
    logic          win_end;

    // Threshold counts the current block, so compare against one below it.
    assign unlock  = blk_valid && blk_bad && (err_cnt == ERR_LAST);
    assign win_end = blk_valid && (win_cnt == WIN_LAST);

    // Window/error counters; unlock and window end both restart the window.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            win_cnt <= '0;
            err_cnt <= '0;
        end else if (blk_valid) begin
            if (unlock || win_end) begin
                win_cnt <= '0;
                err_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                if (blk_bad) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pcie_130b_block_sync_ctrl.sv
// 128b/130b block alignment: hunts via gearbox slips, locks, monitors header errors.
// Latency: every block-driven output is registered, visible 1 cycle after blk_valid.
// Backpressure: none on blocks; slip_req is held until the gearbox returns slip_ack.
module pcie_130b_block_sync_ctrl
    import pcie_pcs_pkg::*;
#(
    parameter int LOCK_CNT   = 64,
    parameter int WIN_LEN    = 64,
    parameter int ERR_THRESH = 16,
    parameter int BLANK_BLK  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        blk_valid,
    input  logic [1:0]  blk_header,
    input  logic        slip_ack,
    output logic        slip_req,
    output logic        block_lock,
    output logic        descr_seed_load,
    output logic        descr_en,
    output logic        hdr_err,
    output logic [7:0]  slip_cnt,
    output logic [15:0] lock_loss_cnt,
    output logic [2:0]  sync_state
);

    localparam int GW = cnt_width(LOCK_CNT);
    localparam int BW = cnt_width(BLANK_BLK);
    localparam logic [GW-1:0] LOCK_TARGET = GW'(LOCK_CNT);
    localparam logic [BW-1:0] BLANK_INIT  = BW'(BLANK_BLK);

    blk_sync_state_e state, state_nxt;
    logic [GW-1:0]   good_cnt, good_cnt_nxt;
    logic [BW-1:0]   blank_cnt, blank_cnt_nxt;
    logic            slip_req_nxt, block_lock_nxt, seed_load_nxt, descr_en_nxt, hdr_err_nxt;
    logic [7:0]      slip_cnt_nxt;
    logic [15:0]     lock_loss_cnt_nxt;
    logic            hdr_ok, go_slip, go_lock, win_unlock;
    logic [GW-1:0]   good_inc;

    assign hdr_ok     = hdr_is_ok(blk_header);
    assign good_inc   = good_cnt + 1'b1;
    assign sync_state = state;

    pcie_blk_err_window #(
        .WIN_LEN    (WIN_LEN),
        .ERR_THRESH (ERR_THRESH)
    ) u_err_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (go_lock),
        .blk_valid (blk_valid && (state == LOCKED)),
        .blk_bad   (!hdr_ok),
        .unlock    (win_unlock)
    );

    // Next-state and next-output decode; entry actions applied after the case.
    always_comb begin
        state_nxt         = state;
        good_cnt_nxt      = good_cnt;
        blank_cnt_nxt     = blank_cnt;
        slip_req_nxt      = slip_req;
        block_lock_nxt    = block_lock;
        seed_load_nxt     = 1'b0;
        descr_en_nxt      = 1'b0;
        hdr_err_nxt       = 1'b0;
        slip_cnt_nxt      = slip_cnt;
        lock_loss_cnt_nxt = lock_loss_cnt;
        go_slip           = 1'b0;
        go_lock           = 1'b0;

        case (state)
            HUNT: begin
                if (blk_valid) begin
                    if (!hdr_ok) begin
                        hdr_err_nxt = 1'b1;
                        go_slip     = 1'b1;
                    end else if (LOCK_CNT == 1) begin
                        go_lock = 1'b1;
                    end else begin
                        state_nxt    = TEST;
                        good_cnt_nxt = GW'(1);
                    end
                end
            end
            SLIP: begin
                if (slip_ack && slip_req) begin
                    slip_req_nxt = 1'b0;
                    if (BLANK_BLK == 0) begin
                        state_nxt = HUNT;
                    end else begin
                        state_nxt     = BLANK;
                        blank_cnt_nxt = BLANK_INIT;
                    end
                end
            end
            BLANK: begin
                if (blk_valid) begin
                    blank_cnt_nxt = blank_cnt - 1'b1;
                    if (blank_cnt == BW'(1)) begin
                        state_nxt = HUNT;
                    end
                end
            end
            TEST: begin
                if (blk_valid) begin
                    if (!hdr_ok) begin
                        hdr_err_nxt  = 1'b1;
                        good_cnt_nxt = '0;
                        go_slip      = 1'b1;
                    end else if (good_inc == LOCK_TARGET) begin
                        go_lock = 1'b1;
                    end else begin
                        good_cnt_nxt = good_inc;
                    end
                end
            end
            LOCKED: begin
                if (blk_valid) begin
                    hdr_err_nxt  = !hdr_ok;
                    descr_en_nxt = (blk_header == HDR_DATA);
                    if (win_unlock) begin
                        block_lock_nxt    = 1'b0;
                        lock_loss_cnt_nxt = (lock_loss_cnt == 16'hFFFF) ?
                                            lock_loss_cnt : lock_loss_cnt + 16'd1;
                        go_slip           = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase

        if (go_slip) begin
            state_nxt    = SLIP;
            slip_req_nxt = 1'b1;
            slip_cnt_nxt = (slip_cnt == 8'hFF) ? slip_cnt : slip_cnt + 8'd1;
        end
        if (go_lock) begin
            state_nxt      = LOCKED;
            block_lock_nxt = 1'b1;
            seed_load_nxt  = 1'b1;
            slip_cnt_nxt   = '0;
            good_cnt_nxt   = '0;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= HUNT;
            good_cnt        <= '0;
            blank_cnt       <= '0;
            slip_req        <= 1'b0;
            block_lock      <= 1'b0;
            descr_seed_load <= 1'b0;
            descr_en        <= 1'b0;
            hdr_err         <= 1'b0;
            slip_cnt        <= '0;
            lock_loss_cnt   <= '0;
        end else begin
            state           <= state_nxt;
            good_cnt        <= good_cnt_nxt;
            blank_cnt       <= blank_cnt_nxt;
            slip_req        <= slip_req_nxt;
            block_lock      <= block_lock_nxt;
            descr_seed_load <= seed_load_nxt;
            descr_en        <= descr_en_nxt;
            hdr_err         <= hdr_err_nxt;
            slip_cnt        <= slip_cnt_nxt;
            lock_loss_cnt   <= lock_loss_cnt_nxt;
        end
    end

endmodule
